trap_sequencer: RTL and testbench

- Arbitrates all trap sources and the mret instruction, then sequences the machine-mode CSR file and the fetch unit.
- Picks one winning cause per retiring instruction and drives the CSR file's exception/mret strobes with mcause/mepc/mtval.
- Then flushes the pipeline and redirects fetch to mtvec or mepc.
- Tracks the current privilege mode and feeds it to the CSR file.

---
 rtl/trap_sequencer_pkg.sv | 29 ++
 rtl/trap_cause_arbiter.sv | 72 +++++++
 rtl/trap_sequencer.sv | 141 ++++++++++++++
 tb/tb_trap_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_sequencer_pkg.sv
// Shared types and constants for the trap sequencer: FSM states, mcause
// codes, privilege encodings and mstatus/mie bit positions.
package trap_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    T_CSR = 3'd1,
    T_RDR = 3'd2,
    M_CSR = 3'd3,
    M_RDR = 3'd4
  } state_t;

  localparam logic [3:0] CAUSE_MISALIGN = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL  = 4'd2;
  localparam logic [3:0] CAUSE_BREAK    = 4'd3;
  localparam logic [3:0] CAUSE_ECALL_U  = 4'd8;
  localparam logic [3:0] CAUSE_ECALL_M  = 4'd11;
  localparam logic [3:0] CAUSE_MEXT_IRQ = 4'd11;

  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_M = 2'b11;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_HI = 12;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MIE_MEIE       = 11;

endpackage

// File: rtl/trap_cause_arbiter.sv
// Combinational priority encoder over all trap sources and mret.
// TRAP_IRQ_EN: when defined, the external interrupt outranks every
// synchronous cause; otherwise interrupts are never taken.
module trap_cause_arbiter
  import trap_sequencer_pkg::*;
(
  input  logic        inst_valid,
  input  logic [31:0] inst_pc,
  input  logic [31:0] inst_word,
  input  logic        illegal_inst,
  input  logic        ecall_inst,
  input  logic        ebreak_inst,
  input  logic        mret_inst,
  input  logic        irq_pending,
  input  logic [1:0]  priv,
  output logic        take_trap,
  output logic        take_mret,
  output logic [3:0]  cause,
  output logic        is_irq,
  output logic [31:0] mtval
);

  logic irq_req;

`ifdef TRAP_IRQ_EN
  assign irq_req = irq_pending;
`else
  logic unused_irq;
  assign unused_irq = irq_pending;
  assign irq_req    = 1'b0;
`endif

  // Walk the causes from highest to lowest priority; first hit wins.
  always_comb begin
    take_trap = 1'b0;
    take_mret = 1'b0;
    cause     = CAUSE_MISALIGN;
    is_irq    = 1'b0;
    mtval     = '0;
    if (inst_valid) begin
      if (irq_req) begin
        take_trap = 1'b1;
        cause     = CAUSE_MEXT_IRQ;
        is_irq    = 1'b1;
      end else if (inst_pc[1:0] != 2'b00) begin
        take_trap = 1'b1;
        cause     = CAUSE_MISALIGN;
        mtval     = inst_pc;
      end else if (illegal_inst) begin
        take_trap = 1'b1;
        cause     = CAUSE_ILLEGAL;
        mtval     = inst_word;
      end else if (ebreak_inst) begin
        take_trap = 1'b1;
        cause     = CAUSE_BREAK;
      end else if (ecall_inst) begin
        take_trap = 1'b1;
        cause     = (priv == PRIV_M) ? CAUSE_ECALL_M : CAUSE_ECALL_U;
      end else if (mret_inst) begin
        if (priv == PRIV_M) begin
          take_mret = 1'b1;
        end else begin
          // mret outside M-mode is an illegal instruction
          take_trap = 1'b1;
          cause     = CAUSE_ILLEGAL;
          mtval     = inst_word;
        end
      end
    end
  end

endmodule

// File: rtl/trap_sequencer.sv
// Trap/mret sequencer: arbitrates one cause per retiring instruction,
// strobes the CSR file, then flushes and redirects fetch two cycles later.
// TRAP_IRQ_EN enables external interrupt arbitration (see trap_cause_arbiter).
module trap_sequencer
  import trap_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [1:0]  RESET_PRIV = 2'b00
) (
  input  logic        clk,
  input  logic        reset_x,
  input  logic        inst_valid,
  input  logic [31:0] inst_pc,
  input  logic [31:0] inst_word,
  input  logic        illegal_inst,
  input  logic        ecall_inst,
  input  logic        ebreak_inst,
  input  logic        mret_inst,
  input  logic        ext_irq,
  input  logic [31:0] mstatus_in,
  input  logic [31:0] mie_in,
  input  logic [31:0] mtvec_in,
  input  logic [31:0] mepc_in,
  output logic        exception,
  output logic        mret,
  output logic [3:0]  mcause_out,
  output logic        trap_is_irq,
  output logic [31:0] mepc_out,
  output logic [31:0] mtval_out,
  output logic [1:0]  priv_mode,
  output logic        stall,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  state_t      state, state_nxt;
  logic        take_trap, take_mret, arb_irq;
  logic [3:0]  arb_cause;
  logic [31:0] arb_mtval;
  logic [3:0]  cause_q;
  logic        irq_q;
  logic [31:0] epc_q, tval_q, last_pc_q;
  logic [1:0]  priv_q, mpp_q;
  logic        irq_pending;

  // Only a handful of CSR bits matter here; the rest are intentionally dropped.
  logic unused_csr_bits;
  assign unused_csr_bits = ^{mstatus_in, mie_in, mtvec_in[1:0]};

  assign irq_pending = ext_irq & mstatus_in[MSTATUS_MIE] & mie_in[MIE_MEIE];

  trap_cause_arbiter u_arb (
    .inst_valid  (inst_valid),
    .inst_pc     (inst_pc),
    .inst_word   (inst_word),
    .illegal_inst(illegal_inst),
    .ecall_inst  (ecall_inst),
    .ebreak_inst (ebreak_inst),
    .mret_inst   (mret_inst),
    .irq_pending (irq_pending),
    .priv        (priv_q),
    .take_trap   (take_trap),
    .take_mret   (take_mret),
    .cause       (arb_cause),
    .is_irq      (arb_irq),
    .mtval       (arb_mtval)
  );

  // State register; reset aborts any sequence in flight.
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state: each non-IDLE state lasts exactly one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (take_trap)      state_nxt = T_CSR;
        else if (take_mret) state_nxt = M_CSR;
      end
      T_CSR:   state_nxt = T_RDR;
      T_RDR:   state_nxt = IDLE;
      M_CSR:   state_nxt = M_RDR;
      M_RDR:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the winning cause in IDLE, commit privilege on the redirect cycle.
  // MPP is captured on entry to M_CSR, ahead of the CSR file's negedge write.
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      cause_q   <= '0;
      irq_q     <= 1'b0;
      epc_q     <= '0;
      tval_q    <= '0;
      mpp_q     <= PRIV_U;
      priv_q    <= RESET_PRIV;
      last_pc_q <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          if (take_trap) begin
            cause_q <= arb_cause;
            irq_q   <= arb_irq;
            epc_q   <= inst_pc;
            tval_q  <= arb_mtval;
          end else if (take_mret) begin
            mpp_q <= mstatus_in[MSTATUS_MPP_HI:MSTATUS_MPP_LO];
          end
        end
        T_RDR: begin
          priv_q    <= PRIV_M;
          last_pc_q <= {mtvec_in[31:2], 2'b00};
        end
        M_RDR: begin
          priv_q    <= mpp_q;
          last_pc_q <= mepc_in;
        end
        default: ;
      endcase
    end
  end

  assign exception      = (state == T_CSR);
  assign mret           = (state == M_CSR);
  assign flush          = (state == T_CSR) || (state == M_CSR);
  assign redirect_valid = (state == T_RDR) || (state == M_RDR);
  assign stall          = (state != IDLE);
  assign mcause_out     = cause_q;
  assign trap_is_irq    = irq_q;
  assign mepc_out       = epc_q;
  assign mtval_out      = tval_q;
  assign priv_mode      = priv_q;
  assign redirect_pc    = (state == T_RDR) ? {mtvec_in[31:2], 2'b00} :
                          (state == M_RDR) ? mepc_in : last_pc_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: directed table, multi-cycle
// reset corners, and random instructions against a priority-list model.
module tb_trap_sequencer;

  logic        clk = 1'b0;
  logic        reset_x;
  logic        inst_valid, illegal_inst, ecall_inst, ebreak_inst, mret_inst, ext_irq;
  logic [31:0] inst_pc, inst_word, mstatus_in, mie_in, mtvec_in, mepc_in;
  logic        exception, mret, trap_is_irq, stall, flush, redirect_valid;
  logic [3:0]  mcause_out;
  logic [31:0] mepc_out, mtval_out, redirect_pc;
  logic [1:0]  priv_mode;

  trap_sequencer dut (
    .clk(clk), .reset_x(reset_x), .inst_valid(inst_valid), .inst_pc(inst_pc),
    .inst_word(inst_word), .illegal_inst(illegal_inst), .ecall_inst(ecall_inst),
    .ebreak_inst(ebreak_inst), .mret_inst(mret_inst), .ext_irq(ext_irq),
    .mstatus_in(mstatus_in), .mie_in(mie_in), .mtvec_in(mtvec_in), .mepc_in(mepc_in),
    .exception(exception), .mret(mret), .mcause_out(mcause_out),
    .trap_is_irq(trap_is_irq), .mepc_out(mepc_out), .mtval_out(mtval_out),
    .priv_mode(priv_mode), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        valid, ill, ec, eb, mr, irq;
    bit [31:0] pc, word, mstat, mie;
  } stim_t;

  typedef struct {
    int        kind;   // 0 none, 1 trap, 2 mret
    bit [3:0]  cause;
    bit        irq;
    bit [31:0] mtval;
  } exp_t;

  typedef struct {
    bit [1:0]  priv;
    stim_t     s;
    bit [31:0] tvec, epc;
    exp_t      e;
  } vec_t;

  typedef struct { bit [3:0] cause; bit [31:0] mtval; bit irq; } cand_t;

  int       n_cmp = 0;
  int       n_bad = 0;
  bit [1:0] m_priv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference: list every cause that applies in priority order, take the first.
  function automatic exp_t model(input stim_t s, input bit [1:0] priv);
    exp_t  e;
    cand_t q[$];
    bit    irq_on;
    e = '{kind: 0, cause: 4'd0, irq: 1'b0, mtval: 32'd0};
    if (!s.valid) return e;
    irq_on = 1'b0;
`ifdef TRAP_IRQ_EN
    irq_on = s.irq && s.mstat[3] && s.mie[11];
`endif
    if (irq_on)                q.push_back('{4'd11, 32'd0, 1'b1});
    if (s.pc % 4 != 0)         q.push_back('{4'd0, s.pc, 1'b0});
    if (s.ill)                 q.push_back('{4'd2, s.word, 1'b0});
    if (s.eb)                  q.push_back('{4'd3, 32'd0, 1'b0});
    if (s.ec)                  q.push_back('{(priv == 2'b11) ? 4'd11 : 4'd8, 32'd0, 1'b0});
    if (s.mr && priv != 2'b11) q.push_back('{4'd2, s.word, 1'b0});
    if (q.size() > 0) begin
      e.kind = 1; e.cause = q[0].cause; e.mtval = q[0].mtval; e.irq = q[0].irq;
    end else if (s.mr) begin
      e.kind = 2;
    end
    return e;
  endfunction

  function automatic stim_t mk(input bit v, ill, ec, eb, mr, irq,
                               input bit [31:0] pc, word, mstat, mie);
    stim_t s;
    s.valid = v; s.ill = ill; s.ec = ec; s.eb = eb; s.mr = mr; s.irq = irq;
    s.pc = pc; s.word = word; s.mstat = mstat; s.mie = mie;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    inst_valid = s.valid; illegal_inst = s.ill; ecall_inst = s.ec;
    ebreak_inst = s.eb; mret_inst = s.mr; ext_irq = s.irq;
    inst_pc = s.pc; inst_word = s.word; mstatus_in = s.mstat; mie_in = s.mie;
  endtask

  task automatic drive_idle();
    drive(mk(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0));
  endtask

  // One instruction from IDLE through the full sequence; inputs during the
  // sequence are scrambled to show they are ignored outside IDLE.
  task automatic run(input string tag, input stim_t s, input exp_t e,
                     input bit [31:0] tvec, input bit [31:0] epc);
    bit [1:0] mpp;
    @(negedge clk);
    drive(s);
    mpp = s.mstat[12:11];
    @(negedge clk);
    if (e.kind == 0) begin
      chk({tag, " idle_exc"}, {31'd0, exception}, 32'd0);
      chk({tag, " idle_mret"}, {31'd0, mret}, 32'd0);
      chk({tag, " idle_stall"}, {31'd0, stall}, 32'd0);
      drive_idle();
      return;
    end
    if (e.kind == 1) begin
      chk({tag, " exc"}, {31'd0, exception}, 32'd1);
      chk({tag, " mret0"}, {31'd0, mret}, 32'd0);
      chk({tag, " mcause"}, {28'd0, mcause_out}, {28'd0, e.cause});
      chk({tag, " irq"}, {31'd0, trap_is_irq}, {31'd0, e.irq});
      chk({tag, " mepc"}, mepc_out, s.pc);
      chk({tag, " mtval"}, mtval_out, e.mtval);
    end else begin
      chk({tag, " mret"}, {31'd0, mret}, 32'd1);
      chk({tag, " exc0"}, {31'd0, exception}, 32'd0);
    end
    chk({tag, " flush"}, {31'd0, flush}, 32'd1);
    chk({tag, " stall1"}, {31'd0, stall}, 32'd1);
    // CSR file update lands here (negedge inside the CSR cycle)
    drive(mk($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom, $urandom, $urandom, $urandom));
    mtvec_in = tvec;
    mepc_in  = epc;
    @(negedge clk);
    chk({tag, " rdr_v"}, {31'd0, redirect_valid}, 32'd1);
    chk({tag, " rdr_pc"}, redirect_pc, (e.kind == 1) ? (tvec & ~32'd3) : epc);
    chk({tag, " rdr_stall"}, {31'd0, stall}, 32'd1);
    chk({tag, " rdr_exc"}, {31'd0, exception | mret | flush}, 32'd0);
    m_priv = (e.kind == 1) ? 2'b11 : mpp;
    drive_idle();
    @(negedge clk);
    chk({tag, " priv"}, {30'd0, priv_mode}, {30'd0, m_priv});
    chk({tag, " done"}, {31'd0, stall | redirect_valid}, 32'd0);
  endtask

  task automatic set_priv(input bit [1:0] p);
    stim_t s;
    if (m_priv == p) return;
    if (p == 2'b11) s = mk(1, 0, 1, 0, 0, 0, 32'h40, 32'h0, 32'h0, 32'h0);
    else            s = mk(1, 0, 0, 0, 1, 0, 32'h44, 32'h0, 32'h0, 32'h0);
    run("setpriv", s, model(s, m_priv), 32'h800, 32'h300);
  endtask

  vec_t tbl[14];

  initial begin
    drive_idle();
    mtvec_in = 32'h0; mepc_in = 32'h0;
    m_priv  = 2'b00;
    reset_x = 1'b0;
    #1;
    chk("rst_exc", {31'd0, exception}, 32'd0);
    chk("rst_priv", {30'd0, priv_mode}, 32'd0);
    chk("rst_pc", redirect_pc, 32'h0);
    chk("rst_stall", {31'd0, stall | flush | redirect_valid | mret}, 32'd0);
    repeat (2) @(negedge clk);
    reset_x = 1'b1;

    // {priv, stimulus, mtvec, mepc, expected}
    tbl[0]  = '{2'b00, mk(1,1,0,0,0,0, 32'h100, 32'hFFFF_FFFF, 32'h0, 32'h0), 32'h1003, 32'h0, '{1, 4'd2, 1'b0, 32'hFFFF_FFFF}};
    tbl[1]  = '{2'b00, mk(1,0,1,0,0,0, 32'h200, 32'h0000_0073, 32'h0, 32'h0), 32'h2000, 32'h0, '{1, 4'd8, 1'b0, 32'h0}};
    tbl[2]  = '{2'b11, mk(1,0,1,0,0,0, 32'h204, 32'h0000_0073, 32'h0, 32'h0), 32'h2002, 32'h0, '{1, 4'd11, 1'b0, 32'h0}};
    tbl[3]  = '{2'b11, mk(1,0,0,0,1,0, 32'h300, 32'h3020_0073, 32'h0, 32'h0), 32'h0, 32'h204, '{2, 4'd0, 1'b0, 32'h0}};
    tbl[4]  = '{2'b00, mk(1,0,0,0,1,0, 32'h304, 32'h3020_0073, 32'h0, 32'h0), 32'h4000, 32'h0, '{1, 4'd2, 1'b0, 32'h3020_0073}};
    tbl[5]  = '{2'b00, mk(1,1,0,1,0,0, 32'h308, 32'hDEAD_BEEF, 32'h0, 32'h0), 32'h4000, 32'h0, '{1, 4'd2, 1'b0, 32'hDEAD_BEEF}};
    tbl[6]  = '{2'b00, mk(1,1,0,0,0,0, 32'h102, 32'h1234_5678, 32'h0, 32'h0), 32'h4000, 32'h0, '{1, 4'd0, 1'b0, 32'h102}};
    tbl[7]  = '{2'b11, mk(1,0,0,1,0,0, 32'h40C, 32'h0010_0073, 32'h0, 32'h0), 32'h5001, 32'h0, '{1, 4'd3, 1'b0, 32'h0}};
    tbl[8]  = '{2'b00, mk(0,1,1,1,1,1, 32'h101, 32'h0, 32'h808, 32'h800), 32'h0, 32'h0, '{0, 4'd0, 1'b0, 32'h0}};
    tbl[9]  = '{2'b11, mk(1,0,0,0,0,0, 32'h500, 32'h0000_0013, 32'h0, 32'h0), 32'h0, 32'h0, '{0, 4'd0, 1'b0, 32'h0}};
`ifdef TRAP_IRQ_EN
    tbl[10] = '{2'b00, mk(1,0,1,0,0,1, 32'h600, 32'h0, 32'h8, 32'h800), 32'h6000, 32'h0, '{1, 4'd11, 1'b1, 32'h0}};
`else
    tbl[10] = '{2'b00, mk(1,0,1,0,0,1, 32'h600, 32'h0, 32'h8, 32'h800), 32'h6000, 32'h0, '{1, 4'd8, 1'b0, 32'h0}};
`endif
    tbl[11] = '{2'b00, mk(1,0,1,0,0,1, 32'h604, 32'h0, 32'h0, 32'h800), 32'h6000, 32'h0, '{1, 4'd8, 1'b0, 32'h0}};
    tbl[12] = '{2'b11, mk(1,0,1,0,1,0, 32'h608, 32'h0, 32'h1800, 32'h0), 32'h7000, 32'h0, '{1, 4'd11, 1'b0, 32'h0}};
    tbl[13] = '{2'b00, mk(0,0,0,0,0,1, 32'h60C, 32'h0, 32'h8, 32'h800), 32'h0, 32'h0, '{0, 4'd0, 1'b0, 32'h0}};

    for (int i = 0; i < 14; i++) begin
      set_priv(tbl[i].priv);
      run($sformatf("vec%0d", i), tbl[i].s, tbl[i].e, tbl[i].tvec, tbl[i].epc);
    end

    // Reset during T_CSR from M-mode: sequence dies, no strobes follow.
    set_priv(2'b11);
    @(negedge clk);
    drive(mk(1, 0, 0, 1, 0, 0, 32'h700, 32'h0, 32'h0, 32'h0));
    @(negedge clk);
    chk("midrst_pre_exc", {31'd0, exception}, 32'd1);
    reset_x = 1'b0;
    drive_idle();
    #1;
    chk("midrst_exc", {31'd0, exception}, 32'd0);
    chk("midrst_priv", {30'd0, priv_mode}, 32'd0);
    chk("midrst_pc", redirect_pc, 32'h0);
    chk("midrst_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    reset_x = 1'b1;
    m_priv  = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("postrst_quiet", {31'd0, exception | mret | redirect_valid | stall}, 32'd0);
    end

    // Random instructions against the reference model.
    for (int i = 0; i < 300; i++) begin
      stim_t s;
      s.valid = ($urandom_range(0, 7) != 0);
      s.ill   = ($urandom_range(0, 3) == 0);
      s.ec    = ($urandom_range(0, 3) == 0);
      s.eb    = ($urandom_range(0, 4) == 0);
      s.mr    = ($urandom_range(0, 2) == 0);
      s.irq   = ($urandom_range(0, 3) == 0);
      s.pc    = {$urandom_range(0, 32'hFFFF), 2'b00} | (($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0);
      s.word  = $urandom;
      s.mstat = ($urandom & ~32'h1808) | ($urandom_range(0, 1) ? 32'h1800 : 32'h0)
                | ($urandom_range(0, 1) ? 32'h8 : 32'h0);
      s.mie   = $urandom;
      run($sformatf("rnd%0d", i), s, model(s, m_priv), $urandom, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
